// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU among NUM_REQ requesters
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_srcA,
  input  logic [NUM_REQ*WIDTH-1:0] req_srcB,
  input  logic [NUM_REQ*3-1:0]     req_op,
  output logic [NUM_REQ-1:0]       resp_valid,
  input  logic [NUM_REQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]         resp_result,
  output logic                     resp_zero,
  output logic [WIDTH-1:0]         alu_srcA,
  output logic [WIDTH-1:0]         alu_srcB,
  output logic [2:0]               alu_control,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic                     alu_zero
);
  localparam int GW = $clog2(NUM_REQ);
  localparam logic [NUM_REQ-1:0] ONE = 1;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic [GW-1:0] rr_q, rr_d, g_q, g_d, gnt, idx;
  logic hit;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0] op_q, op_d;
  logic zero_q, zero_d;
  // descending scan so the nearest valid requester at or after rr_q wins
  always_comb begin
    hit = 1'b0;
    gnt = rr_q;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = GW'((int'(rr_q) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        hit = 1'b1;
        gnt = idx;
      end
    end
  end
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    g_d     = g_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    zero_d  = zero_q;
    case (state_q)
      IDLE: if (hit) begin
        g_d     = gnt;
        a_d     = req_srcA[gnt*WIDTH +: WIDTH];
        b_d     = req_srcB[gnt*WIDTH +: WIDTH];
        op_d    = req_op[gnt*3 +: 3];
        state_d = EXEC;
      end
      EXEC: begin
        res_d   = alu_result;
        zero_d  = alu_zero;
        state_d = RESP;
      end
      RESP: if (resp_ready[g_q]) begin
        rr_d    = (int'(g_q) == NUM_REQ - 1) ? '0 : g_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      g_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      g_q     <= g_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
  end
  // acceptance is suppressed while reset is held, even though the FSM already reads IDLE
  assign req_ready   = (rst_n && state_q == IDLE && hit) ? ONE << gnt : '0;
  assign resp_valid  = (state_q == RESP) ? ONE << g_q : '0;
  assign resp_result = res_q;
  assign resp_zero   = zero_q;
  assign alu_srcA    = a_q;
  assign alu_srcB    = b_q;
  assign alu_control = op_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random transactions against a transaction-level arbitration model
module tb_alu_arbiter;
  localparam int N = 3;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] req_valid = '0, req_ready, resp_valid, resp_ready = '0;
  logic [N*W-1:0] req_srcA = '0, req_srcB = '0;
  logic [N*3-1:0] req_op = '0;
  logic [W-1:0] resp_result, alu_srcA, alu_srcB, alu_result;
  logic [2:0] alu_control;
  logic resp_zero, alu_zero;
  int checks = 0, failures = 0;
  int rr = 0;
  logic [W-1:0] A[N], B[N];
  logic [2:0] OP[N];

  alu_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_srcA(req_srcA), .req_srcB(req_srcB), .req_op(req_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_zero(resp_zero),
    .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    case (op)
      3'b000: return a & b;
      3'b001: return a | b;
      3'b010: return a + b;
      3'b110: return a - b;
      3'b111: return ($signed(a) < $signed(b)) ? 1 : 0;
      default: return '0;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_f(alu_srcA, alu_srcB, alu_control);
    alu_zero   = (alu_result == '0);
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [N-1:0] mask);
    req_valid = mask;
    for (int i = 0; i < N; i++) begin
      req_srcA[i*W +: W] = A[i];
      req_srcB[i*W +: W] = B[i];
      req_op[i*3 +: 3]   = OP[i];
    end
  endtask

  task automatic rand_ops();
    for (int i = 0; i < N; i++) begin
      A[i]  = $urandom;
      B[i]  = ($urandom_range(0, 3) == 0) ? A[i] : $urandom;
      OP[i] = 3'($urandom);
    end
  endtask

  // one complete transaction: grant from the model's pointer, EXEC, RESP held for stall extra cycles
  task automatic txn(input logic [N-1:0] mask, input int stall);
    int g;
    logic [W-1:0] er;
    logic [N-1:0] oh;
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && mask[(rr + k) % N]) g = (rr + k) % N;
    er = alu_f(A[g], B[g], OP[g]);
    oh = '0;
    oh[g] = 1'b1;
    drive(mask);
    #1;
    chk("grant", req_ready, oh);
    @(posedge clk); #1;
    req_valid[g] = 1'b0;
    chk("exec_req_ready", req_ready, 0);
    chk("exec_resp_valid", resp_valid, 0);
    chk("alu_srcA", alu_srcA, A[g]);
    chk("alu_srcB", alu_srcB, B[g]);
    chk("alu_control", alu_control, OP[g]);
    @(posedge clk); #1;
    for (int s = 0; s <= stall; s++) begin
      chk("resp_valid", resp_valid, oh);
      chk("resp_result", resp_result, er);
      chk("resp_zero", resp_zero, er == '0);
      chk("resp_req_ready", req_ready, 0);
      resp_ready = (s == stall) ? (N'($urandom) | oh) : (N'($urandom) & ~oh);
      @(posedge clk); #1;
    end
    resp_ready = '0;
    req_valid  = '0;
    chk("resp_done", resp_valid, 0);
    rr = (g + 1) % N;
  endtask

  initial begin
    #2;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_result", resp_result, 0);
    chk("rst_resp_zero", resp_zero, 0);
    chk("rst_alu_srcA", alu_srcA, 0);
    chk("rst_alu_srcB", alu_srcB, 0);
    chk("rst_alu_control", alu_control, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rand_ops();
    A[0] = 5; B[0] = 7; OP[0] = 3'b010;
    txn(3'b001, 0);
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      txn(3'b011, 0);
    end
    rand_ops();
    A[1] = 9; B[1] = 9; OP[1] = 3'b110;
    txn(3'b010, 10);
    A[0] = 32'hF0F0; B[0] = 32'h0FF0; OP[0] = 3'b000; txn(3'b001, 0);
    OP[0] = 3'b001; txn(3'b001, 0);
    A[0] = 3; B[0] = 8; OP[0] = 3'b111; txn(3'b001, 0);
    A[0] = 8; B[0] = 3; txn(3'b001, 0);
    A[0] = 32'h1234; B[0] = 32'h5678; OP[0] = 3'b011; txn(3'b001, 0);
    A[2] = 32'hFFFF_FFFF; B[2] = 1; OP[2] = 3'b111; txn(3'b100, 0);
    rand_ops(); txn(3'b101, 0);
    rand_ops(); txn(3'b010, 0);
    A[1] = 1; B[1] = 2; OP[1] = 3'b010;
    drive(3'b010);
    #1;
    chk("midop_grant", req_ready, 3'b010);
    @(posedge clk); #1;
    req_valid = 3'b110;
    rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", req_ready, 0);
    chk("midrst_resp_valid", resp_valid, 0);
    chk("midrst_alu_srcA", alu_srcA, 0);
    chk("midrst_alu_control", alu_control, 0);
    chk("midrst_resp_result", resp_result, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("inrst_resp_valid", resp_valid, 0);
    rst_n = 1'b1;
    rr = 0;
    rand_ops();
    txn(3'b110, 1);
    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] m;
      rand_ops();
      m = N'($urandom_range(1, (1 << N) - 1));
      txn(m, $urandom_range(0, 3));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
